// File: rtl/fetch_unit_if.sv
// Instruction memory port between the fetch stage and imem.
// Request is held until ack; ack marks rdata valid.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem req/ack, output reg + 1-entry skid,
// MIPS single-delay-slot redirects from decode.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  fetch_unit_if.master          mem,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_addr,
  output logic [31:0]           id_inst
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rpc_q, rpc_d;
  logic                  pend_q, pend_d;
  logic                  ov_q, ov_d;
  logic [ADDR_WIDTH-1:0] oa_q, oa_d;
  logic [31:0]           oi_q, oi_d;
  logic                  sv_q, sv_d;
  logic [ADDR_WIDTH-1:0] sa_q, sa_d;
  logic [31:0]           si_q, si_d;

  logic                  consume;
  logic                  ack;
  logic                  take;
  logic [ADDR_WIDTH-1:0] pc_inc;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = pc_q;
  assign id_valid     = ov_q;
  assign id_addr      = oa_q;
  assign id_inst      = oi_q;

  assign consume = ov_q && !stall_i;
  assign ack     = req_q && mem.mem_ack;
  assign take    = consume && branch_flag && !pend_q;
  assign pc_inc  = pc_q + ADDR_WIDTH'(4);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    pend_d  = pend_q;
    ov_d    = ov_q;
    oa_d    = oa_q;
    oi_d    = oi_q;
    sv_d    = sv_q;
    sa_d    = sa_q;
    si_d    = si_q;

    // Delay slot already in skid: nothing in flight, redirect now.
    // Otherwise the DS is the current fetch; defer unless it acks now.
    if (take) begin
      if (sv_q) begin
        pc_d = branch_addr;
      end else if (!ack) begin
        pend_d = 1'b1;
        rpc_d  = branch_addr;
      end
    end

    unique case (state_q)
      S_FETCH: begin
        if (ack) begin
          if (pend_q) begin
            pc_d   = rpc_q;
            pend_d = 1'b0;
          end else if (take) begin
            pc_d = branch_addr;
          end else begin
            pc_d = pc_inc;
          end
          if (!ov_q || consume) begin
            ov_d = 1'b1;
            oa_d = pc_q;
            oi_d = mem.mem_rdata;
          end else begin
            sv_d    = 1'b1;
            sa_d    = pc_q;
            si_d    = mem.mem_rdata;
            state_d = S_HOLD;
            req_d   = 1'b0;
          end
        end else begin
          req_d = 1'b1;
          if (consume) ov_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (consume) begin
          oa_d    = sa_q;
          oi_d    = si_q;
          sv_d    = 1'b0;
          state_d = S_FETCH;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      rpc_q   <= '0;
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
      oa_q    <= '0;
      oi_q    <= '0;
      sv_q    <= 1'b0;
      sa_q    <= '0;
      si_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
      oa_q    <= oa_d;
      oi_q    <= oi_d;
      sv_q    <= sv_d;
      sa_q    <= sa_d;
      si_q    <= si_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue model of the fetch/decode
// pipe plus directed literal expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall;
  logic        bf;
  logic [31:0] ba;
  logic [31:0] slow_addr;
  int          wcnt;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  logic        idv, idv2;
  logic [31:0] ida, ida2, idi, idi2;

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  fetch_unit_if #(.ADDR_WIDTH(32)) mif ();
  fetch_unit_if #(.ADDR_WIDTH(32)) mif2 ();

  fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'hBFC0_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .branch_flag(bf),
    .branch_addr(ba),
    .mem        (mif),
    .id_valid   (idv),
    .id_addr    (ida),
    .id_inst    (idi)
  );

  fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'hFFFF_FFF8)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (1'b0),
    .branch_flag(1'b0),
    .branch_addr(32'h0),
    .mem        (mif2),
    .id_valid   (idv2),
    .id_addr    (ida2),
    .id_inst    (idi2)
  );

  // Memory: 3 wait cycles on slow_addr, otherwise same-cycle ack.
  int lat;
  assign lat = (mif.mem_addr == slow_addr) ? 3 : 0;
  assign mif.mem_ack   = mif.mem_req && (wcnt >= lat);
  assign mif.mem_rdata = f(mif.mem_addr);
  assign mif2.mem_ack   = mif2.mem_req;
  assign mif2.mem_rdata = f(mif2.mem_addr);

  always @(posedge clk) begin
    if (!rst || !mif.mem_req || mif.mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: words fetched but not yet consumed by decode (max 2).
  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
  } w_t;
  w_t          q[$];
  logic [31:0] m_pc, m_rpc, m_ds, m_la, m_li;
  bit          m_started, m_pend, m_init;

  initial begin
    m_init = 0;
    forever begin
      @(posedge clk);
      m_init = 1;
      if (!rst) begin
        q.delete();
        m_pc = 32'hBFC0_0000;
        m_rpc = 0;
        m_ds = 0;
        m_la = 0;
        m_li = 0;
        m_started = 0;
        m_pend = 0;
      end else begin
        bit          cons, ack, pend0;
        logic [31:0] ds, nxt;
        cons  = (q.size() > 0) && !stall;
        ack   = m_started && (q.size() < 2) && mif.mem_ack;
        pend0 = m_pend;
        nxt   = m_pc + 32'd4;
        if (cons && bf && !m_pend) begin
          ds = q[0].a + 32'd4;
          if (q.size() > 1 && q[1].a == ds) m_pc = ba;
          else if (ack && m_pc == ds) nxt = ba;
          else begin
            m_pend = 1;
            m_rpc  = ba;
            m_ds   = ds;
          end
        end
        if (ack && pend0 && m_pc == m_ds) begin
          nxt = m_rpc;
          m_pend = 0;
        end
        if (cons) begin
          m_la = q[0].a;
          m_li = q[0].i;
          void'(q.pop_front());
        end
        if (ack) begin
          q.push_back('{a: m_pc, i: f(m_pc)});
          m_pc = nxt;
        end
        m_started = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        bit exp_req;
        exp_req = m_started && (q.size() < 2);
        chk("m_req", {31'b0, mif.mem_req}, {31'b0, exp_req});
        if (exp_req) chk("m_addr", mif.mem_addr, m_pc);
        chk("m_valid", {31'b0, idv}, {31'b0, q.size() > 0});
        chk("m_idaddr", ida, (q.size() > 0) ? q[0].a : m_la);
        chk("m_idinst", idi, (q.size() > 0) ? q[0].i : m_li);
      end
    end
  end

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int k);
    goto(k);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    stall = 0;
    bf = 0;
    ba = 0;
    slow_addr = 32'hBFC0_0004;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_req", {31'b0, mif.mem_req}, 0);
    chk("rst_valid", {31'b0, idv}, 0);
    chk("rst_idaddr", ida, 0);
    chk("rst_req2", {31'b0, mif2.mem_req}, 0);
    at_neg(1);
    chk("c1_req", {31'b0, mif.mem_req}, 1);
    chk("c1_addr", mif.mem_addr, 32'hBFC0_0000);
    chk("w_addr0", mif2.mem_addr, 32'hFFFF_FFF8);
    at_neg(2);
    chk("c2_valid", {31'b0, idv}, 1);
    chk("c2_idaddr", ida, 32'hBFC0_0000);
    chk("c2_idinst", idi, f(32'hBFC0_0000));
    chk("c2_addr", mif.mem_addr, 32'hBFC0_0004);
    chk("w_addr1", mif2.mem_addr, 32'hFFFF_FFFC);
    chk("w_idaddr", ida2, 32'hFFFF_FFF8);
    at_neg(3);
    chk("gap_valid", {31'b0, idv}, 0);
    chk("gap_addr", mif.mem_addr, 32'hBFC0_0004);
    chk("w_addr2", mif2.mem_addr, 32'h0000_0000);
    at_neg(4);
    chk("w_addr3", mif2.mem_addr, 32'h0000_0004);
    at_neg(5);
    chk("gap_req", {31'b0, mif.mem_req}, 1);
    chk("gap_addr5", mif.mem_addr, 32'hBFC0_0004);
    at_neg(6);
    chk("gap_idaddr", ida, 32'hBFC0_0004);
    slow_addr = 32'hBFC0_001C;
    goto(8);
    stall = 1;
    at_neg(10);
    chk("hold_req", {31'b0, mif.mem_req}, 0);
    chk("hold_idaddr", ida, 32'hBFC0_000C);
    goto(13);
    stall = 0;
    @(negedge clk);
    chk("rel_id0", ida, 32'hBFC0_000C);
    at_neg(14);
    chk("rel_id1", ida, 32'hBFC0_0010);
    at_neg(15);
    chk("rel_id2", ida, 32'hBFC0_0014);
    goto(17);
    rst = 0;
    @(negedge clk);
    chk("mid_req", {31'b0, mif.mem_req}, 1);
    chk("mid_addr", mif.mem_addr, 32'hBFC0_001C);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mrst_req", {31'b0, mif.mem_req}, 0);
    chk("mrst_valid", {31'b0, idv}, 0);
    slow_addr = 32'hBFC0_0014;
    @(posedge clk);
    #1 rst = 1;
    goto(6);
    bf = 1;
    ba = 32'hBFC0_0100;
    @(negedge clk);
    chk("br_idaddr", ida, 32'hBFC0_0010);
    goto(7);
    bf = 0;
    at_neg(9);
    chk("ds_addr", mif.mem_addr, 32'hBFC0_0014);
    at_neg(10);
    chk("tgt_addr", mif.mem_addr, 32'hBFC0_0100);
    chk("ds_idaddr", ida, 32'hBFC0_0014);
    at_neg(11);
    chk("tgt_idaddr", ida, 32'hBFC0_0100);
    goto(12);
    stall = 1;
    at_neg(13);
    chk("sk_req", {31'b0, mif.mem_req}, 0);
    goto(14);
    stall = 0;
    bf = 1;
    ba = 32'hBFC0_0200;
    goto(15);
    bf = 0;
    @(negedge clk);
    chk("sk_addr", mif.mem_addr, 32'hBFC0_0200);
    chk("sk_idaddr", ida, 32'hBFC0_0108);
    goto(16);
    bf = 1;
    ba = 32'hBFC0_0300;
    @(negedge clk);
    chk("ack_addr", mif.mem_addr, 32'hBFC0_0204);
    goto(17);
    bf = 0;
    @(negedge clk);
    chk("same_addr", mif.mem_addr, 32'hBFC0_0300);
    chk("same_id", ida, 32'hBFC0_0204);
    at_neg(18);
    chk("same_tgt", ida, 32'hBFC0_0300);
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
